check_strip_parity: RTL and testbench

Downstream companion to the parity-insertion stage on the storage read path. It accepts packed words with parity from the memory read port, checks odd parity per word, strips the parity bits, and presents data to the consumer through a 2-stage valid/ready pipeline. It also produces a per-word error mask aligned with each output beat and keeps error statistics.

---
 rtl/check_strip_parity_if.sv | 25 ++
 rtl/check_strip_parity.sv | 98 +++++++++
 tb/tb_check_strip_parity.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/check_strip_parity_if.sv
// Beat handshake bundle between the parity check/strip stage and its neighbours:
// parity-packed words in, stripped words plus per-word error mask out.
interface check_strip_parity_if #(
  parameter int WORDS         = 5,
  parameter int BITS_PER_WORD = 9
);
  logic [(BITS_PER_WORD+1)*WORDS-1:0] din;
  logic                               din_valid;
  logic                               din_ready;
  logic [BITS_PER_WORD*WORDS-1:0]     dout;
  logic                               dout_valid;
  logic                               dout_ready;
  logic [WORDS-1:0]                   word_err;
  logic                               any_err;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, word_err, any_err
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, word_err, any_err
  );
endinterface

// File: rtl/check_strip_parity.sv
// Odd-parity check and strip, 2-stage valid/ready pipeline (2-cycle latency, holds 2 beats when
// stalled, din_ready = ~dout_valid | dout_ready); error stats only when CHECK_PARITY_STATS_EN is defined.
module check_strip_parity #(
  parameter int WORDS         = 5,
  parameter int BITS_PER_WORD = 9,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     arst_n,
  check_strip_parity_if.slave      bus,
  input  logic                     clr_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     first_err_valid,
  output logic [WORDS-1:0]         first_err_mask
);
  localparam int B  = BITS_PER_WORD;
  localparam int WB = BITS_PER_WORD + 1;

  logic [B*WORDS-1:0] strip_dat;
  logic [WORDS-1:0]   strip_err;
  logic               s1_vld;
  logic [B*WORDS-1:0] s1_dat;
  logic [WORDS-1:0]   s1_err;
  logic               dout_vld_q;
  logic [B*WORDS-1:0] dout_q;
  logic [WORDS-1:0]   err_q;
  logic               adv;
  logic               err_hs;

  // A word is bad when its parity+data bits XOR to 0 (even number of ones).
  always_comb begin
    strip_dat = '0;
    strip_err = '0;
    for (int i = 0; i < WORDS; i++) begin
      strip_dat[i*B +: B] = bus.din[i*WB +: B];
      strip_err[i]        = ~(^bus.din[i*WB +: WB]);
    end
  end

  assign adv           = ~dout_vld_q | bus.dout_ready;
  assign bus.din_ready = adv;
  assign bus.dout      = dout_q;
  assign bus.dout_valid = dout_vld_q;
  assign bus.word_err  = err_q & {WORDS{dout_vld_q}};
  assign bus.any_err   = dout_vld_q & (|err_q);
  assign err_hs        = dout_vld_q & bus.dout_ready & (|err_q);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s1_vld     <= 1'b0;
      s1_dat     <= '0;
      s1_err     <= '0;
      dout_vld_q <= 1'b0;
      dout_q     <= '0;
      err_q      <= '0;
    end else if (adv) begin
      // din_ready equals adv, so din_valid alone qualifies the capture here.
      s1_vld     <= bus.din_valid;
      if (bus.din_valid) begin
        s1_dat <= strip_dat;
        s1_err <= strip_err;
      end
      dout_vld_q <= s1_vld;
      if (s1_vld) begin
        dout_q <= s1_dat;
        err_q  <= s1_err;
      end
    end
  end

`ifdef CHECK_PARITY_STATS_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_mask  <= '0;
    end else if (clr_err) begin
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_mask  <= '0;
    end else if (err_hs) begin
      if (~&err_count) begin
        err_count <= err_count + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      if (!first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_mask  <= err_q;
      end
    end
  end
`else
  logic unused_stats;
  assign unused_stats    = clr_err ^ err_hs;
  assign err_count       = '0;
  assign first_err_valid = 1'b0;
  assign first_err_mask  = '0;
`endif
endmodule

// File: tb/tb_check_strip_parity.sv
// Directed bench for check_strip_parity: default instance plus a 2-bit counter instance for saturation.
module tb_check_strip_parity;
`ifdef CHECK_PARITY_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst_n = 1'b1;
  logic        clr_err, clr_err2;
  logic [15:0] err_count;
  logic [1:0]  err_count2;
  logic        fev, fev2;
  logic [4:0]  fem, fem2;
  int          n_vec = 0;
  int          n_miss = 0;

  check_strip_parity_if #(.WORDS(5), .BITS_PER_WORD(9)) b ();
  check_strip_parity_if #(.WORDS(5), .BITS_PER_WORD(9)) b2 ();

  check_strip_parity #(.WORDS(5), .BITS_PER_WORD(9), .ERR_CNT_WIDTH(16)) dut (
    .clk(clk), .arst_n(arst_n), .bus(b), .clr_err(clr_err),
    .err_count(err_count), .first_err_valid(fev), .first_err_mask(fem)
  );

  check_strip_parity #(.WORDS(5), .BITS_PER_WORD(9), .ERR_CNT_WIDTH(2)) dut_sat (
    .clk(clk), .arst_n(arst_n), .bus(b2), .clr_err(clr_err2),
    .err_count(err_count2), .first_err_valid(fev2), .first_err_mask(fem2)
  );

  always #5 clk = ~clk;

  function automatic logic [49:0] pk(input logic [44:0] d, input logic [4:0] p);
    logic [49:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r[i*10 +: 10] = {p[i], d[i*9 +: 9]};
    return r;
  endfunction

  function automatic logic [4:0] good_par(input logic [44:0] d);
    logic [4:0] p;
    for (int i = 0; i < 5; i++) p[i] = ~(^d[i*9 +: 9]);
    return p;
  endfunction

  task automatic to_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b.din = '0;  b.din_valid = 1'b0;  b.dout_ready = 1'b1;  clr_err = 1'b0;
    b2.din = '0; b2.din_valid = 1'b0; b2.dout_ready = 1'b1; clr_err2 = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 arst_n = 1'b0;
    #2;
    n_vec++;
    if ({b.dout_valid, b.din_ready, b.any_err, b.word_err, b.dout} !== {1'b0, 1'b1, 1'b0, 5'b0, 45'b0}) begin
      n_miss++;
      $display("FAIL reset_outputs: got vld=%b rdy=%b any=%b werr=%b dout=%h, expected 0 1 0 00000 0",
               b.dout_valid, b.din_ready, b.any_err, b.word_err, b.dout);
    end
    n_vec++;
    if ({err_count, fev, fem, err_count2, fev2, fem2} !== '0) begin
      n_miss++;
      $display("FAIL reset_stats: got cnt=%0d fev=%b fem=%b cnt2=%0d, expected all 0", err_count, fev, fem, err_count2);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) arst_n = 1'b1;
  endtask

  task automatic test_good_data();
    to_cycle(); b.din = pk(45'h0, 5'b11111); b.din_valid = 1'b1; #1;
    n_vec++;
    if (b.dout_valid !== 1'b0) begin n_miss++; $display("FAIL good_c0_vld: got %b expected 0", b.dout_valid); end
    to_cycle(); b.din_valid = 1'b0; #1;
    n_vec++;
    if (b.dout_valid !== 1'b0) begin n_miss++; $display("FAIL good_latency: got vld %b expected 0", b.dout_valid); end
    to_cycle(); #1;
    n_vec++;
    if ({b.dout_valid, b.dout, b.word_err, b.any_err} !== {1'b1, 45'h0, 5'b00000, 1'b0}) begin
      n_miss++;
      $display("FAIL good_beat: got vld=%b dout=%h werr=%b any=%b, expected 1 0 00000 0", b.dout_valid, b.dout, b.word_err, b.any_err);
    end
    to_cycle(); #1;
    n_vec++;
    if ({b.dout_valid, err_count} !== {1'b0, 16'd0}) begin
      n_miss++;
      $display("FAIL good_after: got vld=%b cnt=%0d, expected 0 0", b.dout_valid, err_count);
    end
  endtask

  task automatic test_single_bad();
    to_cycle(); b.din = pk(45'd1 << 18, 5'b11111); b.din_valid = 1'b1; #1;
    to_cycle(); b.din_valid = 1'b0; #1;
    to_cycle(); #1;
    n_vec++;
    if ({b.dout_valid, b.dout, b.word_err, b.any_err} !== {1'b1, 45'd1 << 18, 5'b00100, 1'b1}) begin
      n_miss++;
      $display("FAIL bad_beat: got vld=%b dout=%h werr=%b any=%b, expected 1 %h 00100 1",
               b.dout_valid, b.dout, b.word_err, b.any_err, 45'd1 << 18);
    end
    to_cycle(); #1;
    n_vec++;
    if ({err_count, fev, fem} !== (STATS ? {16'd1, 1'b1, 5'b00100} : 22'd0)) begin
      n_miss++;
      $display("FAIL bad_stats: got cnt=%0d fev=%b fem=%b, stats_en=%b", err_count, fev, fem, STATS);
    end
  endtask

  task automatic test_backpressure();
    logic [44:0] bp_dat [4];
    int in_idx, out_idx;
    bp_dat[0] = 45'h0123456789A; bp_dat[1] = 45'h1FEDCBA9876;
    bp_dat[2] = 45'h0A5A5A5A5A5; bp_dat[3] = 45'h15A5A5A5A5A;
    in_idx = 0; out_idx = 0;
    for (int c = 0; c < 14; c++) begin
      to_cycle();
      b.dout_ready = !(c >= 3 && c <= 5);
      b.din_valid  = (in_idx < 4);
      b.din        = (in_idx < 4) ? pk(bp_dat[in_idx], good_par(bp_dat[in_idx])) : '0;
      #1;
      if (c >= 3 && c <= 5) begin
        n_vec++;
        if ({b.dout_valid, b.din_ready, b.dout} !== {1'b1, 1'b0, bp_dat[1]}) begin
          n_miss++;
          $display("FAIL bp_stall c%0d: got vld=%b rdy=%b dout=%h, expected 1 0 %h", c, b.dout_valid, b.din_ready, b.dout, bp_dat[1]);
        end
      end
      if (b.dout_valid && b.dout_ready) begin
        n_vec++;
        if (out_idx >= 4) begin
          n_miss++;
          $display("FAIL bp_extra_beat: got dout=%h, expected no beat", b.dout);
        end else if ({b.dout, b.word_err} !== {bp_dat[out_idx], 5'b0}) begin
          n_miss++;
          $display("FAIL bp_order beat%0d: got %h werr=%b, expected %h 00000", out_idx, b.dout, b.word_err, bp_dat[out_idx]);
        end
        out_idx++;
      end
      if (b.din_valid && b.din_ready) in_idx++;
    end
    n_vec++;
    if (out_idx !== 4) begin n_miss++; $display("FAIL bp_count: got %0d beats, expected 4", out_idx); end
    idle_inputs();
  endtask

  task automatic test_saturation();
    int          tbl [8] = '{0, 0, 0, 1, 2, 3, 3, 3};
    logic [1:0]  exp_cnt;
    for (int c = 0; c < 8; c++) begin
      to_cycle();
      b2.din_valid = (c < 5);
      b2.din       = (c == 0) ? pk(45'd1, 5'b11111) : pk(45'd1 << 9, 5'b11111);
      #1;
      exp_cnt = STATS ? 2'(tbl[c]) : 2'd0;
      n_vec++;
      if ({err_count2, fev2, fem2} !== {exp_cnt, (STATS && c >= 3), ((STATS && c >= 3) ? 5'b00001 : 5'b00000)}) begin
        n_miss++;
        $display("FAIL sat c%0d: got cnt=%0d fev=%b fem=%b, expected cnt=%0d", c, err_count2, fev2, fem2, exp_cnt);
      end
    end
    idle_inputs();
  endtask

  task automatic test_clear_priority();
    to_cycle(); b.din = pk(45'd1 << 36, 5'b11111); b.din_valid = 1'b1; #1;
    to_cycle(); b.din_valid = 1'b0; #1;
    to_cycle(); clr_err = 1'b1; #1;
    n_vec++;
    if ({b.word_err, err_count} !== {5'b10000, (STATS ? 16'd1 : 16'd0)}) begin
      n_miss++;
      $display("FAIL clr_pre: got werr=%b cnt=%0d, expected 10000 %0d", b.word_err, err_count, STATS);
    end
    to_cycle(); clr_err = 1'b0; b.din = pk(45'd1 << 27, 5'b11111); b.din_valid = 1'b1; #1;
    n_vec++;
    if ({err_count, fev, fem} !== 22'd0) begin
      n_miss++;
      $display("FAIL clr_win: got cnt=%0d fev=%b fem=%b, expected 0 0 00000", err_count, fev, fem);
    end
    to_cycle(); b.din_valid = 1'b0; #1;
    to_cycle(); #1;
    to_cycle(); #1;
    n_vec++;
    if ({err_count, fev, fem} !== (STATS ? {16'd1, 1'b1, 5'b01000} : 22'd0)) begin
      n_miss++;
      $display("FAIL clr_after: got cnt=%0d fev=%b fem=%b, stats_en=%b", err_count, fev, fem, STATS);
    end
  endtask

  task automatic test_reset_mid();
    to_cycle(); b.din = pk(45'h1 | (45'h3 << 9), 5'b11111); b.din_valid = 1'b1; #1;
    to_cycle(); b.din = pk(45'h1FF << 18, 5'b11011); #1;
    to_cycle(); b.din_valid = 1'b0; #1;
    n_vec++;
    if (b.dout_valid !== 1'b1) begin n_miss++; $display("FAIL rst_inflight: got vld %b expected 1", b.dout_valid); end
    arst_n = 1'b0;
    #1;
    n_vec++;
    if ({b.dout_valid, b.din_ready, b.any_err, b.word_err, b.dout, err_count, fev, fem} !==
        {1'b0, 1'b1, 1'b0, 5'b0, 45'b0, 16'd0, 1'b0, 5'b0}) begin
      n_miss++;
      $display("FAIL rst_mid: got vld=%b rdy=%b any=%b werr=%b dout=%h cnt=%0d fev=%b fem=%b, expected 0 1 0 0 0 0 0 0",
               b.dout_valid, b.din_ready, b.any_err, b.word_err, b.dout, err_count, fev, fem);
    end
    @(negedge clk) arst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      to_cycle(); #1;
      n_vec++;
      if ({b.dout_valid, b.din_ready} !== 2'b01) begin
        n_miss++;
        $display("FAIL rst_stale c%0d: got vld=%b rdy=%b, expected 0 1", c, b.dout_valid, b.din_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_data();
    test_single_bad();
    test_backpressure();
    test_saturation();
    test_clear_priority();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
